lcd_bus_writer: RTL and testbench
=================================

Name: lcd_bus_writer

Overview:
- 8080-style parallel write engine for the game's display path.
- Sits between the dinoGame renderer, which produces command/data bytes, and the pad mux that drives the parallel LCD pins: chip select, command/data select, write strobe, read strobe and the 8-bit data bus.
- Buffers bytes in a small FIFO and generates correctly timed write strobes.
- Keeps chip select low across consecutive same-type bytes (burst).

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- WR_LOW_CYCLES, 2, clk cycles wr is held low per byte; >=1.
- WR_HIGH_CYCLES, 2, clk cycles wr is held high after its rising edge per byte; >=1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- in_byte  input  8  byte to write.
- in_is_data  input  1  1 = pixel/parameter data (cd=1), 0 = command (cd=0).
- in_valid  input  1  producer has a byte.
- in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready at a clk edge.
- cs  output  1  LCD chip select, active-low.
- cd  output  1  LCD command/data select.
- wr  output  1  LCD write strobe, active-low; panel latches on rising edge.
- rd  output  1  LCD read strobe; tied 1 (write-only block).
- data  output  8  LCD data bus.
- busy  output  1  1 while FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (rst=0 at an edge):
  - cs=1, cd=1, wr=1, rd=1, data=0, busy=0, in_ready=1.
  - FIFO flushed (count=0, pointers=0), FSM -> IDLE, cycle counter=0.
  - Applies mid-transaction too: no partial strobe completes, and buffered bytes are discarded.
- All outputs are registered.
- FIFO:
  - 9-bit entries {is_data, byte}; count width $clog2(DEPTH+1); pointers wrap modulo DEPTH.
  - in_ready = (count != DEPTH), decoded from the registered count.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Order is strictly FIFO.
- FSM states: IDLE, SETUP, WR_LO, WR_HI, HOLD.
  - IDLE:
    - cs=1, wr=1.
    - If count>0: pop head, register data, cd and cs=0, then -> SETUP.
    - A byte pushed at edge E0 into an empty FIFO is popped at E1, so cs falls after E1.
  - SETUP: one cycle; cs=0, wr=1, data/cd stable; -> WR_LO.
  - WR_LO: wr=0 for exactly WR_LOW_CYCLES cycles; -> WR_HI.
  - WR_HI:
    - wr=1 for exactly WR_HIGH_CYCLES cycles.
    - At its last cycle, if count>0 and head is_data == current cd: pop, load data, stay cs=0, -> WR_LO (burst; no SETUP).
    - Otherwise -> HOLD.
  - HOLD: one cycle with cs=0, wr=1, data/cd held; -> IDLE with cs=1.
- Invariants:
  - data and cd change only at the edge that enters SETUP, or at the WR_HI -> WR_LO burst edge.
  - They are never changed while wr=0.
  - cd changes only while cs=1 (i.e., on IDLE -> SETUP).
  - IDLE lasts at least one cycle between non-burst transactions.
- Timing:
  - Single isolated byte: cs low for 1 + WR_LOW_CYCLES + WR_HIGH_CYCLES + 1 cycles.
  - Burst byte period: WR_LOW_CYCLES + WR_HIGH_CYCLES cycles.
- busy = (state != IDLE) || (count != 0), registered alongside state.
- Bytes with in_valid=1 and in_ready=0 are not taken; the producer must hold them.

Test Plan:
1. Hold rst=0 for 3 cycles, then release with in_valid=0 -> cs=wr=rd=cd=1, data=0x00, busy=0, in_ready=1; no strobe for 20 cycles.
2. Push 0x2A with in_is_data=0 at E0 (defaults) ->
   - cs=0, cd=0, data=0x2A after E1.
   - wr=0 exactly 2 cycles from E2.
   - wr rises at E4; cs=0 for 6 cycles total, then cs=1 and busy=0.
3. Push 0x11, 0x22, 0x33, 0x44 back-to-back with in_is_data=1 ->
   - cs low continuously, single SETUP.
   - 4 wr pulses, one every 4 cycles.
   - Each byte appears on data while wr=0, in order.
   - cs rises one HOLD cycle after the last WR_HI.
4. Push command 0x2C then data 0xFF ->
   - Two separate cs-low windows separated by >=1 IDLE cycle with cs=1.
   - cd goes 0 -> 1 only while cs=1.
5. DEPTH=4, WR_LOW_CYCLES=WR_HIGH_CYCLES=4; hold in_valid=1 for 8 consecutive bytes 0xA0..0xA7 ->
   - in_ready drops when count reaches 4.
   - All 8 bytes emitted in order, none lost or duplicated.
   - in_ready never high while count=4.
6. Pull rst=0 for one edge during the 2nd WR_LO cycle of a 3-byte burst ->
   - Next cycle cs=wr=1, data=0, busy=0, in_ready=1.
   - No further wr pulses; remaining bytes are discarded.

Source files
------------

// File: rtl/lcd_bus_writer.sv
// Purpose: 8080-style parallel LCD write engine; buffers {is_data, byte} in a
//          small FIFO and emits timed active-low write strobes, holding cs low
//          across consecutive same-type bytes.
// Latency: a byte pushed at edge E0 into an empty FIFO drives cs/cd/data after
//          E1; wr falls after E2.
// Backpressure: in_ready drops while the FIFO holds DEPTH entries; the producer
//          must hold in_valid/in_byte/in_is_data until accepted.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   in_byte, in_is_data, in_valid, in_ready : producer handshake
//   cs, cd, wr, rd, data                    : LCD pins (cs/wr active-low, rd tied 1)
//   busy                                    : FIFO non-empty or engine active
module lcd_bus_writer #(
    parameter int DEPTH          = 4,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_byte,
    input  logic       in_is_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cs,
    output logic       cd,
    output logic       wr,
    output logic       rd,
    output logic [7:0] data,
    output logic       busy
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int MAXC = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]   LO_LAST = CW'(WR_LOW_CYCLES - 1);
    localparam logic [CW-1:0]   HI_LAST = CW'(WR_HIGH_CYCLES - 1);
    localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_LO,
        WR_HI,
        HOLD
    } state_t;

    // FIFO storage
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_nxt;
    logic [8:0]      head;
    logic            push;
    logic            pop;

    // Engine state
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cyc;
    logic [CW-1:0] cyc_nxt;
    logic          cs_nxt;
    logic          cd_nxt;
    logic          wr_nxt;
    logic [7:0]    data_nxt;
    logic          busy_nxt;

    // Decoded from the registered count, so a full FIFO refuses a push even
    // if a pop happens in the same cycle.
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign rd       = 1'b1;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNTW'(1);
            2'b01:   count_nxt = count - CNTW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        cs_nxt    = cs;
        cd_nxt    = cd;
        wr_nxt    = wr;
        data_nxt  = data;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                cs_nxt = 1'b1;
                wr_nxt = 1'b1;
                if (count != '0) begin
                    // cd may only change here, where cs is still high.
                    pop       = 1'b1;
                    data_nxt  = head[7:0];
                    cd_nxt    = head[8];
                    cs_nxt    = 1'b0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                wr_nxt    = 1'b0;
                cyc_nxt   = '0;
                state_nxt = WR_LO;
            end
            WR_LO: begin
                if (cyc == LO_LAST) begin
                    wr_nxt    = 1'b1;
                    cyc_nxt   = '0;
                    state_nxt = WR_HI;
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            WR_HI: begin
                if (cyc == HI_LAST) begin
                    // Burst continues only for a same-type byte, so cd never
                    // moves while cs is low.
                    if ((count != '0) && (head[8] == cd)) begin
                        pop       = 1'b1;
                        data_nxt  = head[7:0];
                        wr_nxt    = 1'b0;
                        cyc_nxt   = '0;
                        state_nxt = WR_LO;
                    end else begin
                        state_nxt = HOLD;
                    end
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            HOLD: begin
                cs_nxt    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                cs_nxt    = 1'b1;
                wr_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy_nxt = (state_nxt != IDLE) || (count_nxt != '0);

    // Entry storage carries no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_is_data, in_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cyc    <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cs     <= 1'b1;
            cd     <= 1'b1;
            wr     <= 1'b1;
            data   <= 8'h00;
            busy   <= 1'b0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_nxt;
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cs   <= cs_nxt;
            cd   <= cd_nxt;
            wr   <= wr_nxt;
            data <= data_nxt;
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: instance 0 uses default timing (2/2),
// instance 1 uses 4/4 strobe timing for the full-FIFO stream.
module tb_lcd_bus_writer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ib [2];
    logic [1:0] iv;
    logic [1:0] id;
    logic [1:0] rdy_o, cs_o, cd_o, wr_o, rd_o, busy_o;
    logic [7:0] data_o [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_bus_writer #(.DEPTH(DEPTH), .WR_LOW_CYCLES(2), .WR_HIGH_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .in_byte(ib[0]), .in_is_data(id[0]), .in_valid(iv[0]),
        .in_ready(rdy_o[0]), .cs(cs_o[0]), .cd(cd_o[0]), .wr(wr_o[0]), .rd(rd_o[0]),
        .data(data_o[0]), .busy(busy_o[0])
    );

    lcd_bus_writer #(.DEPTH(DEPTH), .WR_LOW_CYCLES(4), .WR_HIGH_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .in_byte(ib[1]), .in_is_data(id[1]), .in_valid(iv[1]),
        .in_ready(rdy_o[1]), .cs(cs_o[1]), .cd(cd_o[1]), .wr(wr_o[1]), .rd(rd_o[1]),
        .data(data_o[1]), .busy(busy_o[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transaction is: one setup cycle, then one strobe period of L+H cycles
    // per byte (wr low for the first L), then one hold cycle.
    int         m_low [2] = '{2, 4};
    int         m_per [2] = '{4, 8};
    bit         m_ok [2];
    logic       m_cs [2], m_cd [2], m_wr [2], m_busy [2];
    logic [7:0] m_data [2];
    bit         m_win [2], m_setup [2], m_hold [2];
    int         m_t [2];
    logic [8:0] mbuf [2][16];
    int         mhd [2], mcnt [2];

    task automatic model_take(input int i);
        m_data[i] = mbuf[i][mhd[i]][7:0];
        m_cd[i]   = mbuf[i][mhd[i]][8];
        mhd[i]    = (mhd[i] + 1) % 16;
        mcnt[i]   = mcnt[i] - 1;
    endtask

    task automatic model_step(input int i, input logic rstv, input logic vld, input logic [8:0] din);
        bit acc;
        if (!rstv) begin
            m_ok[i] = 1; m_cs[i] = 1; m_cd[i] = 1; m_wr[i] = 1; m_busy[i] = 0;
            m_data[i] = 8'h00; m_win[i] = 0; m_setup[i] = 0; m_hold[i] = 0;
            m_t[i] = 0; mhd[i] = 0; mcnt[i] = 0;
            return;
        end
        acc = vld && (mcnt[i] != DEPTH);
        if (!m_win[i]) begin
            if (mcnt[i] != 0) begin
                model_take(i);
                m_win[i] = 1; m_setup[i] = 1; m_hold[i] = 0; m_cs[i] = 0; m_wr[i] = 1;
            end
        end else if (m_setup[i]) begin
            m_setup[i] = 0; m_t[i] = 0; m_wr[i] = 0;
        end else if (m_hold[i]) begin
            m_hold[i] = 0; m_win[i] = 0; m_cs[i] = 1;
        end else begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] == m_per[i]) begin
                if (mcnt[i] != 0 && mbuf[i][mhd[i]][8] == m_cd[i]) begin
                    model_take(i);
                    m_t[i] = 0; m_wr[i] = 0;
                end else begin
                    m_hold[i] = 1; m_wr[i] = 1;
                end
            end else begin
                m_wr[i] = (m_t[i] < m_low[i]) ? 1'b0 : 1'b1;
            end
        end
        if (acc) begin
            mbuf[i][(mhd[i] + mcnt[i]) % 16] = din;
            mcnt[i] = mcnt[i] + 1;
        end
        m_busy[i] = m_win[i] || (mcnt[i] != 0);
    endtask

    always @(posedge clk) begin
        model_step(0, rst, iv[0], {id[0], ib[0]});
        model_step(1, rst, iv[1], {id[1], ib[1]});
    end

    // ---------------- per-cycle compare + monitors ----------------
    int         cs_low_n [2], wr_low_n [2], win_n [2], pulse_n [2], ncap [2], viol [2];
    int         gmin [2], gmax [2], lastf [2];
    logic [7:0] cap [2][16];
    bit         saw_full [2];
    logic       pcs [2], pwr [2], pcd [2];
    logic [7:0] pdat [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_ok[i]) begin
                check($sformatf("model cs[%0d]", i),   cs_o[i],   m_cs[i]);
                check($sformatf("model cd[%0d]", i),   cd_o[i],   m_cd[i]);
                check($sformatf("model wr[%0d]", i),   wr_o[i],   m_wr[i]);
                check($sformatf("model rd[%0d]", i),   rd_o[i],   1'b1);
                check($sformatf("model data[%0d]", i), data_o[i], m_data[i]);
                check($sformatf("model busy[%0d]", i), busy_o[i], m_busy[i]);
                check($sformatf("model in_ready[%0d]", i), rdy_o[i], (mcnt[i] != DEPTH));

                if (!cs_o[i]) cs_low_n[i]++;
                if (!wr_o[i]) wr_low_n[i]++;
                if (pcs[i] && !cs_o[i]) win_n[i]++;
                if (pwr[i] && !wr_o[i]) begin
                    pulse_n[i]++;
                    if (ncap[i] < 16) cap[i][ncap[i]] = data_o[i];
                    ncap[i]++;
                    if (lastf[i] >= 0) begin
                        if (cyc - lastf[i] < gmin[i]) gmin[i] = cyc - lastf[i];
                        if (cyc - lastf[i] > gmax[i]) gmax[i] = cyc - lastf[i];
                    end
                    lastf[i] = cyc;
                end
                if (cd_o[i] !== pcd[i] && !pcs[i]) viol[i]++;
                if (!pwr[i] && !wr_o[i] && data_o[i] !== pdat[i]) viol[i]++;
                if (!rdy_o[i]) saw_full[i] = 1;
                pcs[i] = cs_o[i]; pwr[i] = wr_o[i]; pcd[i] = cd_o[i]; pdat[i] = data_o[i];
            end
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            cs_low_n[i] = 0; wr_low_n[i] = 0; win_n[i] = 0; pulse_n[i] = 0;
            ncap[i] = 0; viol[i] = 0; gmin[i] = 1000; gmax[i] = 0; lastf[i] = -1;
            saw_full[i] = 0;
        end
    endtask

    task automatic push(input int i, input logic [7:0] b, input logic isd);
        logic acc;
        int   n;
        n = 0;
        ib[i] = b; id[i] = isd; iv[i] = 1'b1;
        do begin
            acc = rdy_o[i];
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) check($sformatf("push accept timeout[%0d]", i), 0, 1);
    endtask

    task automatic wait_idle(input int i, input int maxc);
        int n;
        n = 0;
        while (busy_o[i] && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (busy_o[i]) check($sformatf("idle timeout[%0d]", i), 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp3 [4];
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33; exp3[3] = 8'h44;
        iv = '0; id = '0; ib[0] = 8'h00; ib[1] = 8'h00;
        clear_mon();

        // 1: reset state and quiet bus
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t1 cs", cs_o[0], 1'b1);
        check("t1 wr", wr_o[0], 1'b1);
        check("t1 cd", cd_o[0], 1'b1);
        check("t1 data", data_o[0], 8'h00);
        check("t1 busy", busy_o[0], 1'b0);
        check("t1 in_ready", rdy_o[0], 1'b1);
        clear_mon();
        repeat (20) @(negedge clk);
        check("t1 no strobes", pulse_n[0] + pulse_n[1], 0);

        // 2: single command byte
        clear_mon();
        push(0, 8'h2A, 1'b0);
        iv[0] = 1'b0;
        @(negedge clk);
        check("t2 cs after E1", cs_o[0], 1'b0);
        check("t2 cd after E1", cd_o[0], 1'b0);
        check("t2 data after E1", data_o[0], 8'h2A);
        check("t2 wr after E1", wr_o[0], 1'b1);
        @(negedge clk);
        check("t2 wr after E2", wr_o[0], 1'b0);
        wait_idle(0, 50);
        check("t2 wr low cycles", wr_low_n[0], 2);
        check("t2 cs low cycles", cs_low_n[0], 6);
        check("t2 pulses", pulse_n[0], 1);
        check("t2 cs idle", cs_o[0], 1'b1);

        // 3: four-byte data burst
        clear_mon();
        push(0, 8'h11, 1'b1);
        push(0, 8'h22, 1'b1);
        push(0, 8'h33, 1'b1);
        push(0, 8'h44, 1'b1);
        iv[0] = 1'b0;
        wait_idle(0, 100);
        check("t3 windows", win_n[0], 1);
        check("t3 pulses", pulse_n[0], 4);
        check("t3 cs low cycles", cs_low_n[0], 18);
        check("t3 wr low cycles", wr_low_n[0], 8);
        check("t3 min period", gmin[0], 4);
        check("t3 max period", gmax[0], 4);
        for (int k = 0; k < 4; k++) check($sformatf("t3 byte %0d", k), cap[0][k], exp3[k]);

        // 4: command then data -> two windows
        clear_mon();
        push(0, 8'h2C, 1'b0);
        push(0, 8'hFF, 1'b1);
        iv[0] = 1'b0;
        wait_idle(0, 100);
        check("t4 windows", win_n[0], 2);
        check("t4 pulses", pulse_n[0], 2);
        check("t4 cs low cycles", cs_low_n[0], 12);
        check("t4 byte 0", cap[0][0], 8'h2C);
        check("t4 byte 1", cap[0][1], 8'hFF);
        check("t4 cd/data stability", viol[0], 0);

        // 5: 8-byte stream into the 4/4 instance, FIFO fills
        clear_mon();
        for (int k = 0; k < 8; k++) push(1, 8'hA0 + 8'(k), 1'b1);
        iv[1] = 1'b0;
        wait_idle(1, 300);
        check("t5 in_ready dropped", saw_full[1], 1'b1);
        check("t5 pulses", pulse_n[1], 8);
        check("t5 windows", win_n[1], 1);
        check("t5 cs low cycles", cs_low_n[1], 66);
        check("t5 period", gmax[1], 8);
        for (int k = 0; k < 8; k++) check($sformatf("t5 byte %0d", k), cap[1][k], 8'hA0 + 8'(k));
        check("t5 cd/data stability", viol[1], 0);

        // 6: reset during 2nd WR_LO cycle of a burst
        clear_mon();
        push(0, 8'h51, 1'b1);
        push(0, 8'h52, 1'b1);
        push(0, 8'h53, 1'b1);
        iv[0] = 1'b0;
        begin
            int n;
            n = 0;
            while (wr_o[0] && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (wr_o[0]) check("t6 wr low timeout", 0, 1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6 cs", cs_o[0], 1'b1);
        check("t6 wr", wr_o[0], 1'b1);
        check("t6 data", data_o[0], 8'h00);
        check("t6 busy", busy_o[0], 1'b0);
        check("t6 in_ready", rdy_o[0], 1'b1);
        clear_mon();
        repeat (30) @(negedge clk);
        check("t6 no further strobes", pulse_n[0], 0);
        check("t6 no further windows", win_n[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
